sha1_padder: RTL and testbench



---
 rtl/sha1_pkg.sv | 37 +++
 rtl/sha1_msgbuf.sv | 36 +++
 rtl/sha1_padder.sv | 254 +++++++++++++++++++++++++
 tb/tb_sha1_padder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// Shared constants, FSM state encoding and IV lookup for the SHA-1 padder slice.
package sha1_pkg;

  localparam logic [31:0] SHA1_H0 = 32'h67452301;
  localparam logic [31:0] SHA1_H1 = 32'hEFCDAB89;
  localparam logic [31:0] SHA1_H2 = 32'h98BADCFE;
  localparam logic [31:0] SHA1_H3 = 32'h10325476;
  localparam logic [31:0] SHA1_H4 = 32'hC3D2E1F0;

  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam logic [5:0] LEN_PTR  = 6'd56;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    PAD80 = 3'd2,
    PADZ  = 3'd3,
    LEN   = 3'd4,
    START = 3'd5,
    WAIT  = 3'd6,
    ACC   = 3'd7
  } state_e;

  function automatic logic [31:0] sha1_iv(input logic [2:0] idx);
    logic [31:0] v;
    case (idx)
      3'd0:    v = SHA1_H0;
      3'd1:    v = SHA1_H1;
      3'd2:    v = SHA1_H2;
      3'd3:    v = SHA1_H3;
      3'd4:    v = SHA1_H4;
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sha1_msgbuf.sv
// 16x32 message block buffer: big-endian byte writes, a length-word write to
// words 14/15, and an asynchronous word read for the compression core.
module sha1_msgbuf (
  input  logic        clk,
  input  logic        i_byte_we,
  input  logic [5:0]  i_byte_addr,
  input  logic [7:0]  i_byte_data,
  input  logic        i_len_we,
  input  logic [63:0] i_len_data,
  input  logic [3:0]  i_raddr,
  output logic [31:0] o_rdata
);

  logic [31:0] r_mem [16];

  // Byte lane 0 of a word is its most significant byte.
  always_ff @(posedge clk) begin
    if (i_len_we) begin
      r_mem[14] <= i_len_data[63:32];
      r_mem[15] <= i_len_data[31:0];
    end else if (i_byte_we) begin
      case (i_byte_addr[1:0])
        2'd0:    r_mem[i_byte_addr[5:2]][31:24] <= i_byte_data;
        2'd1:    r_mem[i_byte_addr[5:2]][23:16] <= i_byte_data;
        2'd2:    r_mem[i_byte_addr[5:2]][15:8]  <= i_byte_data;
        2'd3:    r_mem[i_byte_addr[5:2]][7:0]   <= i_byte_data;
        default: r_mem[i_byte_addr[5:2]][7:0]   <= i_byte_data;
      endcase
    end else begin
      r_mem[0] <= r_mem[0];
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sha1_padder.sv
// SHA-1 message padder and block sequencer: fills the block buffer, runs the
// external compression core one block at a time and accumulates the digest.
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int CNT_W = 61
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_data,
  input  logic         s_last,
  output logic [159:0] digest,
  output logic         digest_valid,
  output logic         busy,
  output logic         core_restart,
  output logic [31:0]  core_h0,
  output logic [31:0]  core_h1,
  output logic [31:0]  core_h2,
  output logic [31:0]  core_h3,
  output logic [31:0]  core_h4,
  input  logic [3:0]   core_raddr,
  output logic [31:0]  core_word,
  input  logic         core_ready,
  input  logic [31:0]  core_a,
  input  logic [31:0]  core_b,
  input  logic [31:0]  core_c,
  input  logic [31:0]  core_d,
  input  logic [31:0]  core_e
);

  state_e             r_state;
  state_e             w_state_nxt;
  state_e             r_nxt;
  state_e             w_nxt_val;
  logic               w_nxt_we;
  logic [5:0]         r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_final;
  logic [31:0]        r_h     [5];
  logic [31:0]        w_core_x[5];
  logic [31:0]        w_sum   [5];
  logic               r_s_ready;
  logic               r_busy;
  logic               r_digest_valid;
  logic [159:0]       r_digest;
  logic               w_accept;
  logic               w_wrap;
  logic               w_byte_we;
  logic [7:0]         w_byte_data;
  logic               w_len_we;
  logic               w_restart;
  logic [63:0]        w_len;

  // r_s_ready is only ever high while the FSM sits in IDLE or FILL.
  assign w_accept = s_valid & r_s_ready;
  assign w_wrap   = (r_ptr == 6'd63);
  assign w_len    = 64'({r_cnt, 3'b000});

  assign w_core_x[0] = core_a;
  assign w_core_x[1] = core_b;
  assign w_core_x[2] = core_c;
  assign w_core_x[3] = core_d;
  assign w_core_x[4] = core_e;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_sum[i] = r_h[i] + w_core_x[i];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_nxt   <= IDLE;
    end else begin
      r_state <= w_state_nxt;
      if (w_nxt_we) begin
        r_nxt <= w_nxt_val;
      end
    end
  end

  // Next-state logic; w_nxt_* records where to resume after a full block.
  always_comb begin
    w_state_nxt = r_state;
    w_nxt_we    = 1'b0;
    w_nxt_val   = r_nxt;
    case (r_state)
      IDLE, FILL: begin
        if (w_accept) begin
          if (w_wrap) begin
            w_state_nxt = START;
            w_nxt_we    = 1'b1;
            if (s_last) begin
              w_nxt_val = PAD80;
            end else begin
              w_nxt_val = FILL;
            end
          end else if (s_last) begin
            w_state_nxt = PAD80;
          end else begin
            w_state_nxt = FILL;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      PAD80: begin
        if (w_wrap) begin
          w_state_nxt = START;
          w_nxt_we    = 1'b1;
          w_nxt_val   = PADZ;
        end else begin
          w_state_nxt = PADZ;
        end
      end
      PADZ: begin
        if (r_ptr == LEN_PTR) begin
          w_state_nxt = LEN;
        end else if (w_wrap) begin
          w_state_nxt = START;
          w_nxt_we    = 1'b1;
          w_nxt_val   = PADZ;
        end else begin
          w_state_nxt = PADZ;
        end
      end
      LEN:   w_state_nxt = START;
      START: begin
        if (core_ready) begin
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = START;
        end
      end
      WAIT: begin
        if (core_ready) begin
          w_state_nxt = ACC;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      ACC: begin
        if (r_final) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = r_nxt;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Per-state buffer writes and core handshake.
  always_comb begin
    w_byte_we   = 1'b0;
    w_byte_data = s_data;
    w_len_we    = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      IDLE, FILL: begin
        w_byte_we   = w_accept;
        w_byte_data = s_data;
      end
      PAD80: begin
        w_byte_we   = 1'b1;
        w_byte_data = PAD_BYTE;
      end
      PADZ: begin
        w_byte_we   = (r_ptr != LEN_PTR);
        w_byte_data = 8'h00;
      end
      LEN:     w_len_we  = 1'b1;
      START:   w_restart = core_ready;
      default: w_byte_we = 1'b0;
    endcase
  end

  // Pointer, byte count, chaining values and digest.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ptr    <= 6'd0;
      r_cnt    <= '0;
      r_final  <= 1'b0;
      r_digest <= 160'd0;
      for (int i = 0; i < 5; i++) begin
        r_h[i] <= sha1_iv(3'(i));
      end
    end else if (r_state == ACC) begin
      if (r_final) begin
        r_digest <= {w_sum[0], w_sum[1], w_sum[2], w_sum[3], w_sum[4]};
        r_ptr    <= 6'd0;
        r_cnt    <= '0;
        r_final  <= 1'b0;
        for (int i = 0; i < 5; i++) begin
          r_h[i] <= sha1_iv(3'(i));
        end
      end else begin
        for (int i = 0; i < 5; i++) begin
          r_h[i] <= w_sum[i];
        end
      end
    end else begin
      if (w_byte_we) begin
        r_ptr <= r_ptr + 6'd1;
      end
      if (w_accept) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (r_state == LEN) begin
        r_final <= 1'b1;
      end
    end
  end

  // Status outputs registered from the next state so they track the FSM.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_s_ready      <= 1'b0;
      r_busy         <= 1'b0;
      r_digest_valid <= 1'b0;
    end else begin
      r_s_ready      <= (w_state_nxt == IDLE) || (w_state_nxt == FILL);
      r_busy         <= (w_state_nxt != IDLE);
      r_digest_valid <= (r_state == ACC) && r_final;
    end
  end

  sha1_msgbuf u_msgbuf (
    .clk         (clk),
    .i_byte_we   (w_byte_we),
    .i_byte_addr (r_ptr),
    .i_byte_data (w_byte_data),
    .i_len_we    (w_len_we),
    .i_len_data  (w_len),
    .i_raddr     (core_raddr),
    .o_rdata     (core_word)
  );

  assign s_ready      = r_s_ready;
  assign busy         = r_busy;
  assign digest       = r_digest;
  assign digest_valid = r_digest_valid;
  assign core_restart = w_restart;
  assign core_h0      = r_h[0];
  assign core_h1      = r_h[1];
  assign core_h2      = r_h[2];
  assign core_h3      = r_h[3];
  assign core_h4      = r_h[4];

endmodule

// File: tb/tb_sha1_padder.sv
// Bench for sha1_padder: behavioural compression core, known-answer table,
// multi-cycle corner sequences and random messages against a SHA-1 model.
module tb_sha1_padder;

  typedef logic [7:0] byteq_t [$];
  typedef struct {
    string        msg;
    logic [159:0] dig;
    int           restarts;
  } vec_t;

  localparam logic [159:0] IV  = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [159:0] ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;

  logic         clk = 1'b0;
  logic         nrst;
  logic         s_valid, s_ready, s_last;
  logic [7:0]   s_data;
  logic [159:0] digest;
  logic         digest_valid, busy, core_restart;
  logic [31:0]  core_h0, core_h1, core_h2, core_h3, core_h4;
  logic [3:0]   core_raddr;
  logic [31:0]  core_word;
  logic         core_ready;
  logic [31:0]  core_a, core_b, core_c, core_d, core_e;

  int n_cmp = 0, n_bad = 0;
  int n_restart = 0, v_early = 0, v_ready = 0, v_dv = 0;
  logic dv_prev = 1'b0;

  always #5 clk = ~clk;

  sha1_padder dut (
    .clk(clk), .nrst(nrst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .digest(digest), .digest_valid(digest_valid), .busy(busy),
    .core_restart(core_restart), .core_h0(core_h0), .core_h1(core_h1), .core_h2(core_h2),
    .core_h3(core_h3), .core_h4(core_h4), .core_raddr(core_raddr), .core_word(core_word),
    .core_ready(core_ready), .core_a(core_a), .core_b(core_b), .core_c(core_c),
    .core_d(core_d), .core_e(core_e)
  );

  // SHA-1 80-round compression returning the final working variables a..e.
  function automatic logic [159:0] sha1_rounds(input logic [159:0] hv, input logic [511:0] blk);
    logic [31:0] w[80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 80; t++) begin
      tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
      w[t] = {tmp[30:0], tmp[31]};
    end
    {a, b, c, d, e} = hv;
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);         k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                  k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                  k = 32'hCA62C1D6; end
      tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {a, b, c, d, e};
  endfunction

  // Reference digest: pad the whole message as a byte queue, then chain blocks.
  function automatic logic [159:0] sha1_ref(input byteq_t msg);
    byteq_t       m;
    logic [63:0]  bits;
    logic [159:0] h, r;
    logic [511:0] blk;
    m    = msg;
    bits = 64'(msg.size()) * 64'd8;
    m.push_back(8'h80);
    while ((m.size() % 64) != 56) m.push_back(8'h00);
    for (int i = 7; i >= 0; i--) m.push_back(bits[8*i +: 8]);
    h = IV;
    for (int bi = 0; bi < m.size() / 64; bi++) begin
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = m[64*bi + j];
      r = sha1_rounds(h, blk);
      for (int q = 0; q < 5; q++) h[159 - 32*q -: 32] = h[159 - 32*q -: 32] + r[159 - 32*q -: 32];
    end
    return h;
  endfunction

  // Behavioural compression core: reads words 0..15 on its first 16 cycles,
  // reports ready 80 cycles after a restart (or after reset, as a boot run).
  int           cm_t;
  logic         cm_run;
  logic [159:0] cm_h;
  logic [511:0] cm_blk;
  assign core_raddr = 4'(cm_t);

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cm_t <= 0; core_ready <= 1'b0; cm_run <= 1'b0; cm_blk <= '0; cm_h <= '0;
      {core_a, core_b, core_c, core_d, core_e} <= '0;
    end else if (core_restart) begin
      cm_t <= 0; core_ready <= 1'b0; cm_run <= 1'b1;
      cm_h <= {core_h0, core_h1, core_h2, core_h3, core_h4};
    end else if (!core_ready) begin
      if (cm_t < 16) cm_blk[511 - 32*cm_t -: 32] <= core_word;
      if (cm_t == 79) begin
        {core_a, core_b, core_c, core_d, core_e} <= sha1_rounds(cm_h, cm_blk);
        core_ready <= 1'b1;
        cm_run     <= 1'b0;
      end
      cm_t <= cm_t + 1;
    end
  end

  // Protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (nrst) begin
      if (core_restart) begin
        n_restart++;
        if (!core_ready) v_early++;
        if (s_ready) v_ready++;
      end
      if (cm_run && s_ready) v_ready++;
      if (digest_valid && dv_prev) v_dv++;
      dv_prev = digest_valid;
    end else begin
      dv_prev = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic stop_timeout(input string what);
    n_cmp++; n_bad++;
    $display("FAIL %s: timed out waiting for the design", what);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "bench stopped");
  endtask

  task automatic send_bytes(input byteq_t m, input bit with_last, input int gap);
    int b;
    for (int i = 0; i < m.size(); i++) begin
      while ($urandom_range(0, 99) < gap) begin
        s_valid = 1'b0; @(posedge clk); #1;
      end
      s_valid = 1'b1; s_data = m[i]; s_last = with_last && (i == m.size() - 1);
      b = 0;
      while (!s_ready && b < 1000) begin @(posedge clk); #1; b++; end
      if (!s_ready) stop_timeout("s_ready");
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_digest(output logic [159:0] d);
    int b = 0;
    while (!digest_valid && b < 3000) begin @(posedge clk); #1; b++; end
    if (!digest_valid) stop_timeout("digest_valid");
    d = digest;
  endtask

  task automatic run_msg(input string name, input byteq_t m, input int gap, input logic [159:0] exp);
    logic [159:0] d;
    send_bytes(m, 1'b1, gap);
    wait_digest(d);
    chk(name, d, exp);
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    chk({tag, "_s_ready"}, 160'(s_ready), 160'd0);
    chk({tag, "_digest"}, digest, 160'd0);
    chk({tag, "_digest_valid"}, 160'(digest_valid), 160'd0);
    chk({tag, "_core_restart"}, 160'(core_restart), 160'd0);
    chk({tag, "_busy"}, 160'(busy), 160'd0);
    chk({tag, "_core_h"}, {core_h0, core_h1, core_h2, core_h3, core_h4}, IV);
  endtask

  function automatic byteq_t str2q(input string s);
    byteq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  vec_t   tbl[4];
  byteq_t q;
  int     r0;
  int     lens[10];
  logic [159:0] d;

  initial begin
    tbl[0] = '{"abc", ABC, 1};
    tbl[1] = '{"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq",
               160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1, 2};
    tbl[2] = '{"a", 160'h86f7e437_faa5a7fc_e15d1ddc_b9eaeaea_377667b8, 1};
    tbl[3] = '{"The quick brown fox jumps over the lazy dog",
               160'h2fd4e1c6_7a2d28fc_ed849ee1_bb76e739_1b93eb12, 1};
    lens = '{55, 56, 57, 63, 64, 65, 119, 120, 128, 0};

    nrst = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    repeat (3) @(posedge clk);
    check_reset("rst");
    @(posedge clk); #1 nrst = 1'b1;

    // First message right after reset, while the core is still on its boot run.
    r0 = n_restart;
    run_msg("abc_after_reset", str2q("abc"), 0, ABC);
    chk("abc_after_reset_restarts", 160'(n_restart - r0), 160'd1);

    for (int i = 0; i < 4; i++) begin
      r0 = n_restart;
      run_msg({"table_", tbl[i].msg.substr(0, 2)}, str2q(tbl[i].msg), 0, tbl[i].dig);
      chk({"table_restarts_", tbl[i].msg.substr(0, 2)}, 160'(n_restart - r0), 160'(tbl[i].restarts));
    end

    // Back-to-back: the second message starts in the digest_valid cycle.
    run_msg("b2b_first", str2q("abc"), 0, ABC);
    chk("b2b_h_reinit", {core_h0, core_h1, core_h2, core_h3, core_h4}, IV);
    run_msg("b2b_second", str2q("abc"), 0, ABC);

    // Reset after 30 bytes of an unfinished message, then a clean message.
    q = {};
    for (int i = 0; i < 30; i++) q.push_back(8'($urandom));
    send_bytes(q, 1'b0, 10);
    nrst = 1'b0;
    check_reset("midrst");
    @(posedge clk); #1 nrst = 1'b1;
    run_msg("abc_after_midrst", str2q("abc"), 0, ABC);

    // Random messages around block boundaries and with input gaps.
    lens[9] = $urandom_range(1, 180);
    for (int i = 0; i < 10; i++) begin
      q = {};
      for (int j = 0; j < lens[i]; j++) q.push_back(8'($urandom));
      run_msg($sformatf("rand_len%0d", lens[i]), q, $urandom_range(0, 40), sha1_ref(q));
    end
    q = {};
    for (int j = 0; j < 300; j++) q.push_back(8'h61);
    run_msg("a_x300_gaps", q, 30, sha1_ref(q));

    repeat (3) @(posedge clk);
    chk("restart_while_core_busy", 160'(v_early), 160'd0);
    chk("s_ready_while_core_busy", 160'(v_ready), 160'd0);
    chk("digest_valid_single_cycle", 160'(v_dv), 160'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
